// File: rtl/shared_reg_arb_pkg.sv
// Shared definitions for the round-robin shared-register write arbiter:
// FSM state type, default sizing, and the wrap-around first-set search.
package shared_reg_arb_pkg;

  localparam int NUM_REQ_DEF  = 4;
  localparam int DATA_W_DEF   = 8;
  localparam int LOCK_MAX_DEF = 8;
  localparam int RR_MAX       = 16;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // First set bit of req_v at or after ptr, wrapping modulo n (n <= RR_MAX).
  function automatic logic [3:0] rr_pick(input logic [RR_MAX-1:0] req_v,
                                         input logic [3:0]        ptr,
                                         input logic [4:0]        n);
    logic       found;
    logic [4:0] sum;
    logic [4:0] idx;
    found   = 1'b0;
    rr_pick = 4'd0;
    for (int k = 0; k < RR_MAX; k++) begin
      sum = 5'(ptr) + 5'(k);
      idx = (sum >= n) ? (sum - n) : sum;
      if ((5'(k) < n) && !found && req_v[idx[3:0]]) begin
        found   = 1'b1;
        rr_pick = idx[3:0];
      end else begin
        found   = found;
      end
    end
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bundle of the shared-register arbiter: requests, write lanes,
// lock requests, and the registered grant / register-status view.
interface shared_reg_arbiter_if
  import shared_reg_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        lock;
  logic [NUM_REQ-1:0]        gnt;
  logic [DATA_W-1:0]         q;
  logic [IDX_W-1:0]          q_owner;
  logic                      q_valid;
  logic                      locked;

  modport master (
    output req, wdata, lock,
    input  gnt, q, q_owner, q_valid, locked
  );

  modport slave (
    input  req, wdata, lock,
    output gnt, q, q_owner, q_valid, locked
  );
endinterface

// File: rtl/shared_reg_arbiter_reg_en_bank.sv
// DATA_W-wide storage register with asynchronous active-low clear and
// synchronous load enable; the arbiter is its only writer.
module reg_en_bank #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] data_r;

  // Load on enable, clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= '0;
    end else if (en) begin
      data_r <= d;
    end else begin
      data_r <= data_r;
    end
  end

  assign q = data_r;

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter for one shared enable-register. Define
// SHARED_REG_ARB_LOCK_EN to build the LOCKED state (bounded by LOCK_MAX).
module shared_reg_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input logic                 clk,
  input logic                 reset,
  shared_reg_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [NUM_REQ-1:0] GNT_ONE  = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_REQ - 1);

  arb_state_e         state_r, state_nxt_s;
  logic [IDX_W-1:0]   ptr_r, ptr_nxt_s;
  logic [IDX_W-1:0]   owner_r, owner_nxt_s;
  logic [IDX_W-1:0]   win_s, wr_idx_s;
  logic [NUM_REQ-1:0] gnt_r, gnt_nxt_s;
  logic               valid_r, valid_nxt_s;
  logic               locked_r, locked_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic               wr_en_s;
  logic [DATA_W-1:0]  wr_data_s;
  logic [DATA_W-1:0]  q_s;

  assign win_s     = IDX_W'(rr_pick(RR_MAX'(bus.req), 4'(ptr_r), 5'(NUM_REQ)));
  assign wr_data_s = bus.wdata[wr_idx_s*DATA_W +: DATA_W];

`ifndef SHARED_REG_ARB_LOCK_EN
  logic unused_lock_s;
  assign unused_lock_s = ^bus.lock;
`endif

  // Next-state, grant and write-enable decode.
  always_comb begin
    state_nxt_s  = state_r;
    ptr_nxt_s    = ptr_r;
    owner_nxt_s  = owner_r;
    gnt_nxt_s    = '0;
    valid_nxt_s  = valid_r;
    locked_nxt_s = locked_r;
    cnt_nxt_s    = cnt_r;
    wr_en_s      = 1'b0;
    wr_idx_s     = win_s;
    case (state_r)
      ST_IDLE: begin
        if (|bus.req) begin
          wr_en_s     = 1'b1;
          owner_nxt_s = win_s;
          valid_nxt_s = 1'b1;
          gnt_nxt_s   = GNT_ONE << win_s;
          ptr_nxt_s   = (win_s == IDX_LAST) ? '0 : (win_s + IDX_W'(1));
`ifdef SHARED_REG_ARB_LOCK_EN
          if (bus.lock[win_s]) begin
            state_nxt_s  = ST_LOCKED;
            locked_nxt_s = 1'b1;
            cnt_nxt_s    = CNT_W'(1);
          end else begin
            state_nxt_s  = ST_IDLE;
          end
`else
          locked_nxt_s = 1'b0;
`endif
        end else begin
          gnt_nxt_s = '0;
        end
      end
`ifdef SHARED_REG_ARB_LOCK_EN
      // Owner keeps the register until it lets go or the burst budget is spent.
      ST_LOCKED: begin
        if (bus.req[owner_r] && bus.lock[owner_r] && (cnt_r < CNT_W'(LOCK_MAX))) begin
          wr_en_s   = 1'b1;
          wr_idx_s  = owner_r;
          gnt_nxt_s = GNT_ONE << owner_r;
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
          state_nxt_s  = ST_IDLE;
          locked_nxt_s = 1'b0;
          cnt_nxt_s    = '0;
        end
      end
`endif
      default: begin
        state_nxt_s  = ST_IDLE;
        locked_nxt_s = 1'b0;
        cnt_nxt_s    = '0;
      end
    endcase
  end

  // Arbiter state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      ptr_r    <= '0;
      owner_r  <= '0;
      gnt_r    <= '0;
      valid_r  <= 1'b0;
      locked_r <= 1'b0;
      cnt_r    <= '0;
    end else begin
      state_r  <= state_nxt_s;
      ptr_r    <= ptr_nxt_s;
      owner_r  <= owner_nxt_s;
      gnt_r    <= gnt_nxt_s;
      valid_r  <= valid_nxt_s;
      locked_r <= locked_nxt_s;
      cnt_r    <= cnt_nxt_s;
    end
  end

  reg_en_bank #(.DATA_W(DATA_W)) u_bank (
    .clk   (clk),
    .rst_n (reset),
    .en    (wr_en_s),
    .d     (wr_data_s),
    .q     (q_s)
  );

  assign bus.gnt     = gnt_r;
  assign bus.q       = q_s;
  assign bus.q_owner = owner_r;
  assign bus.q_valid = valid_r;
  assign bus.locked  = locked_r;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Randomized and directed bench for shared_reg_arbiter against a
// cycle-level behavioural model; honours SHARED_REG_ARB_LOCK_EN.
module tb_shared_reg_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int DATA_W   = 8;
  localparam int LOCK_MAX = 8;
`ifdef SHARED_REG_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  shared_reg_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  shared_reg_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .DATA_W   (DATA_W),
    .LOCK_MAX (LOCK_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, in plain integers.
  int         m_ptr;
  int         m_owner;
  int         m_cnt;
  bit         m_valid;
  bit         m_locked;
  logic [7:0] m_q;
  logic [3:0] m_gnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_cnt = 0;
    m_valid = 1'b0; m_locked = 1'b0; m_q = 8'h00; m_gnt = 4'b0000;
  endtask

  // One clock edge of the arbiter's rules.
  task automatic model_step();
    int w;
    bit found;
    m_gnt = 4'b0000;
    if (m_locked) begin
      if (bus.req[m_owner] && bus.lock[m_owner] && m_cnt < LOCK_MAX) begin
        m_q = bus.wdata[m_owner*DATA_W +: DATA_W];
        m_gnt[m_owner] = 1'b1;
        m_cnt++;
      end else begin
        m_locked = 1'b0;
        m_cnt = 0;
      end
    end else begin
      found = 1'b0;
      w = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found && bus.req[(m_ptr + k) % NUM_REQ]) begin
          found = 1'b1;
          w = (m_ptr + k) % NUM_REQ;
        end
      end
      if (found) begin
        m_q = bus.wdata[w*DATA_W +: DATA_W];
        m_owner = w;
        m_valid = 1'b1;
        m_gnt[w] = 1'b1;
        m_ptr = (w + 1) % NUM_REQ;
        if (LOCK_EN && bus.lock[w]) begin
          m_locked = 1'b1;
          m_cnt = 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("gnt", 32'(bus.gnt), 32'(m_gnt));
    chk("q", 32'(bus.q), 32'(m_q));
    chk("q_owner", 32'(bus.q_owner), 32'(m_owner));
    chk("q_valid", 32'(bus.q_valid), 32'(m_valid));
    chk("locked", 32'(bus.locked), 32'(m_locked));
  endtask

  // Apply inputs (called at a falling edge), clock once, compare at next falling edge.
  task automatic cycle(input logic [3:0] r, input logic [3:0] l);
    bus.req  = r;
    bus.lock = l;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    logic [3:0] rot_gnt [4];
    logic [7:0] rot_q   [4];
    logic [3:0] wrap_gnt[3];
    n_checks = 0;
    n_errors = 0;
    rot_gnt  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    rot_q    = '{8'h11, 8'h22, 8'h33, 8'h44};
    wrap_gnt = '{4'b0001, 4'b0100, 4'b0001};

    // Reset held with every requester asking.
    reset     = 1'b0;
    bus.req   = 4'b1111;
    bus.lock  = 4'b0000;
    bus.wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    reset = 1'b1;

    // Rotation across all four lanes.
    for (int i = 0; i < 4; i++) begin
      cycle(4'b1111, 4'b0000);
      chk("rot_gnt", 32'(bus.gnt), 32'(rot_gnt[i]));
      chk("rot_q", 32'(bus.q), 32'(rot_q[i]));
    end

    // Pointer wrap after requester 3.
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0101, 4'b0000);
      chk("wrap_gnt", 32'(bus.gnt), 32'(wrap_gnt[i]));
    end

    // Load 0x33 then idle: register holds.
    cycle(4'b0100, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0000, 4'b0000);
      chk("idle_q", 32'(bus.q), 32'h33);
      chk("idle_valid", 32'(bus.q_valid), 32'h1);
    end

`ifdef SHARED_REG_ARB_LOCK_EN
    // Locked burst from requester 1 while 2 waits.
    for (int i = 0; i < LOCK_MAX; i++) begin
      cycle(4'b0110, 4'b0010);
      chk("lock_gnt", 32'(bus.gnt), 32'h2);
      chk("lock_flag", 32'(bus.locked), 32'h1);
    end
    cycle(4'b0110, 4'b0010);
    chk("release_gnt", 32'(bus.gnt), 32'h0);
    chk("release_flag", 32'(bus.locked), 32'h0);
    cycle(4'b0110, 4'b0010);
    chk("after_release_gnt", 32'(bus.gnt), 32'h4);
`endif

    // Reset asserted in the middle of the third write of a burst.
    cycle(4'b0000, 4'b0000);
    bus.wdata = {8'hA4, 8'hA3, 8'hA2, 8'hA1};
    cycle(4'b0010, 4'b0010);
    cycle(4'b0010, 4'b0010);
    @(posedge clk);
    model_step();
    #2 reset = 1'b0;
    #1 model_reset();
    check_outputs();
    chk("midreset_q", 32'(bus.q), 32'h0);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_outputs();
    end
    reset = 1'b1;
    cycle(4'b0001, 4'b0000);
    chk("post_reset_gnt", 32'(bus.gnt), 32'h1);
    chk("post_reset_q", 32'(bus.q), 32'hA1);

    // Randomized traffic, occasional lock requests.
    for (int i = 0; i < 400; i++) begin
      bus.wdata = $urandom;
      cycle(4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin write arbiter and sequencer for a shared enable-register: up to NUM_REQ requesters compete for write access to a single DATA_W-wide register with asynchronous reset and synchronous enable. The arbiter picks at most one writer per cycle, drives the register's enable/data, and returns a one-cycle grant to the winner. It sits between requesting blocks and the shared register.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- DATA_W, 8, width of shared register and of each write-data lane
- LOCK_MAX, 8, max consecutive locked writes before forced release (only with lock feature)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset; all state cleared while low
- req  in  NUM_REQ  per-requester write request, level
- wdata  in  NUM_REQ*DATA_W  write lanes; lane i = wdata[i*DATA_W +: DATA_W]
- lock  in  NUM_REQ  per-requester lock request (ignored when lock feature compiled out)
- gnt  out  NUM_REQ  registered one-hot grant; high for exactly the cycle after a write is accepted
- q  out  DATA_W  shared register contents
- q_owner  out  $clog2(NUM_REQ)  index of the last accepted writer
- q_valid  out  1  high once any write has been accepted since reset
- locked  out  1  high while the resource is locked to one requester

## Operation
- Reset values: gnt=0, q=0, q_owner=0, q_valid=0, locked=0, round-robin pointer ptr=0, state IDLE, lock counter 0.
- States: IDLE (no owner), LOCKED (lock feature only).
- IDLE: winner w = first i with req[i]=1 searching ptr, ptr+1, ... wrapping modulo NUM_REQ. If any req: at the edge q<=lane w, q_owner<=w, q_valid<=1, gnt<=onehot(w), ptr<=(w+1) mod NUM_REQ. If no req: gnt<=0, q/q_owner/ptr hold.
- ptr wrap: winner NUM_REQ-1 sets ptr=0.
- One write per cycle max; gnt never has more than one bit set.
- Requester holding req continuously while others request gets one write per NUM_REQ cycles at worst (strict rotation).
- LOCKED: transition from IDLE when winner w also has lock[w]=1; locked<=1, counter<=1. While in LOCKED: each cycle with req[w]&lock[w] and counter<LOCK_MAX writes lane w (gnt[w] pulses again), counter increments; other requests ignored. Exit to IDLE (locked<=0) when req[w]=0, lock[w]=0, or counter reaches LOCK_MAX; exit cycle performs no write. ptr stays at (w+1) mod NUM_REQ throughout lock.
- reset asserted mid-lock or mid-write: immediate return to reset values, no partial write.

## Timing
- Arbitration combinational from req/ptr/state; all outputs registered.
- Latency: req sampled at edge k -> q, q_owner, gnt valid after edge k (visible during cycle k+1).
- Back-to-back: a continuously requesting sole requester writes every cycle (IDLE) or every cycle up to LOCK_MAX (LOCKED).
- LOCK_MAX forced release: after LOCK_MAX writes, one idle cycle in which locked=0 and no gnt; normal arbitration resumes the following edge.

## Configuration
- SHARED_REG_ARB_LOCK_EN defined: LOCKED state, lock input, LOCK_MAX counter present.
- Not defined: lock ignored, locked tied 0, FSM is IDLE-only, LOCK_MAX unused; pure round-robin.

## Structure
- Package shared_reg_arb_pkg: state enum (IDLE, LOCKED), helper function for round-robin first-set search with wrap, default constants for NUM_REQ/DATA_W/LOCK_MAX.
- One sub-module: reg_en_bank (DATA_W-wide register, async active-low reset, synchronous enable, data in); arbiter drives its enable and data.

## Test plan
- Reset: hold reset low with req=4'b1111 -> gnt=0, q=0, q_owner=0, q_valid=0, locked=0; release -> first grant to requester 0.
- Rotation: req=4'b1111, lanes 0x11/0x22/0x33/0x44 -> gnt 0001,0010,0100,1000,0001 on successive cycles; q follows 0x11,0x22,0x33,0x44.
- Wrap/pointer: after grant to 3, req=4'b0101 -> grant 0 then 2 then 0.
- Idle hold: q=0x33 then req=0 for 5 cycles -> q stays 0x33, gnt=0, q_valid=1.
- Lock (macro on, LOCK_MAX=8): req[1]&lock[1] held, req[2] held -> 8 consecutive gnt[1] with locked=1, one cycle no grant, then gnt[2].
- Reset mid-lock: assert reset during 3rd locked write -> all outputs to reset values asynchronously, no further gnt until release.
